// File: rtl/cpu_pkg.sv
// Package for the instruction sequencer.
// Holds the fixed state encodings, the FSM state type, the opcode/op
// constants, and the regfile data_in select values.
// Macro ILLEGAL_TRAP_EN adds the TRAP state.
package cpu_pkg;

  // State encodings, one value per state.
  localparam logic [2:0] ST_WAIT   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_WR_IMM = 3'd2;
  localparam logic [2:0] ST_GET_A  = 3'd3;
  localparam logic [2:0] ST_GET_B  = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;
  localparam logic [2:0] ST_WR_REG = 3'd6;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] ST_TRAP   = 3'd7;
`endif

  typedef enum logic [2:0] {
    S_WAIT   = ST_WAIT,
    S_DECODE = ST_DECODE,
    S_WR_IMM = ST_WR_IMM,
    S_GET_A  = ST_GET_A,
    S_GET_B  = ST_GET_B,
    S_EXEC   = ST_EXEC,
    S_WR_REG = ST_WR_REG
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = ST_TRAP
`endif
  } state_t;

  // Opcode (IR[15:13]) and op (IR[12:11]) constants.
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  // MOV imm shares op value 10 with AND.
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // Regfile data_in select.
  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Interface between the sequencer, its instruction source and the
// regfile/ALU datapath.
// Handshake: the source drives s/in; an instruction is accepted on a
// rising edge where w = 1 and s = 1. While w = 0, s and in are ignored.
// All datapath controls are driven by the sequencer (master).
// dbg_state / dbg_ir expose the FSM state and the instruction register.
// Macro ILLEGAL_TRAP_EN adds the sticky `illegal` flag.
interface cpu_sequencer_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] sximm8;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        loadc;
  logic        loads;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_ir;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    input  s, in,
    output w, readnum, writenum, write, vsel, sximm8, loada, loadb,
           asel, loadc, loads, shift, aluop, dbg_state, dbg_ir
`ifdef ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output s, in,
    input  w, readnum, writenum, write, vsel, sximm8, loada, loadb,
           asel, loadc, loads, shift, aluop, dbg_state, dbg_ir
`ifdef ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/instr_dec.sv
// Combinational instruction field decoder.
// Ports: ir (16-bit instruction register) in; register fields, shifter op,
// sign-extended immediate and instruction-class flags out.
// is_alu covers all four opcode-101 instructions (ADD, CMP, AND, MVN).
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_legal
);
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu;
endmodule

// File: rtl/cpu_sequencer.sv
// Moore FSM that sequences the 8x16 register file and ALU datapath for one
// instruction at a time.
// Ports: clk (rising edge), reset (synchronous, active high), bus
// (cpu_sequencer_if.master: s/in from the instruction source, regfile and
// datapath controls out, plus debug state/IR).
// Macro ILLEGAL_TRAP_EN: undefined opcodes set a sticky `illegal` flag and
// park the FSM in TRAP until reset; otherwise they are a 2-cycle NOP.
module cpu_sequencer
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            reset,
  cpu_sequencer_if.master bus
);
  state_t      state;
  logic [15:0] ir;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_q;
`endif

  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, shift;
  logic [15:0] sximm8;
  logic        is_mov_imm, is_mov_reg, is_alu, is_cmp, is_legal;

  instr_dec u_dec (
    .ir        (ir),
    .opcode    (opcode),
    .op        (op),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .shift     (shift),
    .sximm8    (sximm8),
    .is_mov_imm(is_mov_imm),
    .is_mov_reg(is_mov_reg),
    .is_alu    (is_alu),
    .is_cmp    (is_cmp),
    .is_legal  (is_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_WAIT: begin
          if (bus.s) begin
            ir    <= bus.in;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b1;
            state     <= S_TRAP;
`else
            state     <= S_WAIT;
`endif
          end else if (is_mov_imm) begin
            state <= S_WR_IMM;
          end else if (is_mov_reg || (op == OP_MVN)) begin
            // Single-operand forms skip A; A is forced to zero in EXEC.
            state <= S_GET_B;
          end else begin
            state <= S_GET_A;
          end
        end
        S_WR_IMM: state <= S_WAIT;
        S_GET_A:  state <= S_GET_B;
        S_GET_B:  state <= S_EXEC;
        S_EXEC:   state <= is_cmp ? S_WAIT : S_WR_REG;
        S_WR_REG: state <= S_WAIT;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   state <= S_TRAP;
`endif
        default:  state <= S_WAIT;
      endcase
    end
  end

  logic       w_d, write_d, vsel_d, loada_d, loadb_d, asel_d, loadc_d, loads_d;
  logic [2:0] readnum_d, writenum_d;

  always_comb begin
    w_d        = 1'b0;
    write_d    = 1'b0;
    vsel_d     = VSEL_C;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    asel_d     = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    case (state)
      S_WAIT: w_d = 1'b1;
      S_WR_IMM: begin
        writenum_d = rn;
        vsel_d     = VSEL_IMM;
        write_d    = 1'b1;
      end
      S_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        asel_d = (opcode == OPC_MOV) || (op == OP_MVN);
        if (is_cmp) loads_d = 1'b1;
        else        loadc_d = 1'b1;
      end
      S_WR_REG: begin
        writenum_d = rd;
        vsel_d     = VSEL_C;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Commit strobes are masked while reset is high so an instruction
  // interrupted by reset never writes the regfile or loads a register.
  assign bus.w         = w_d;
  assign bus.readnum   = readnum_d;
  assign bus.writenum  = writenum_d;
  assign bus.write     = write_d & ~reset;
  assign bus.vsel      = vsel_d;
  assign bus.loada     = loada_d & ~reset;
  assign bus.loadb     = loadb_d & ~reset;
  assign bus.asel      = asel_d;
  assign bus.loadc     = loadc_d & ~reset;
  assign bus.loads     = loads_d & ~reset;
  assign bus.shift     = shift;
  assign bus.aluop     = op;
  assign bus.sximm8    = sximm8;
  assign bus.dbg_state = state;
  assign bus.dbg_ir    = ir;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal   = illegal_q;
`endif
endmodule
